// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// div_pkg : shared widths, result field offsets and FSM states for iter_div
// Rev 1.0
// ============================================================================
package div_pkg;

   localparam int DIV_W    = 32;
   localparam int DIV_ITER = 32;
   localparam int CNT_W    = $clog2(DIV_ITER);

   // Result field offsets, shared with the EXE-stage HI/LO selection
   localparam int QUO_HI = 63;
   localparam int QUO_LO = 32;
   localparam int REM_HI = 31;
   localparam int REM_LO = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

   function automatic logic [DIV_W-1:0] div_mag(input logic [DIV_W-1:0] v,
                                                input logic             neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/iter_div_if.sv
`default_nettype none
// ============================================================================
// iter_div_if : dividend/divisor valid-ready channels and result channel
// Rev 1.0
// ============================================================================
interface iter_div_if;
   import div_pkg::*;

   logic [DIV_W-1:0]   s_axis_dividend_tdata;
   logic               s_axis_dividend_tvalid;
   logic               s_axis_dividend_tready;
   logic [DIV_W-1:0]   s_axis_divisor_tdata;
   logic               s_axis_divisor_tvalid;
   logic               s_axis_divisor_tready;
   logic [2*DIV_W-1:0] m_axis_dout_tdata;
   logic               m_axis_dout_tvalid;

   modport master (
      output s_axis_dividend_tdata, s_axis_dividend_tvalid,
      output s_axis_divisor_tdata,  s_axis_divisor_tvalid,
      input  s_axis_dividend_tready, s_axis_divisor_tready,
      input  m_axis_dout_tdata, m_axis_dout_tvalid
   );

   modport slave (
      input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
      input  s_axis_divisor_tdata,  s_axis_divisor_tvalid,
      output s_axis_dividend_tready, s_axis_divisor_tready,
      output m_axis_dout_tdata, m_axis_dout_tvalid
   );

endinterface
`default_nettype wire

// File: rtl/iter_div_step.sv
`default_nettype none
// ============================================================================
// iter_div_step : one combinational restoring-division step on magnitudes
// Rev 1.0
// ============================================================================
module iter_div_step
   import div_pkg::*;
(
   input  logic [DIV_W:0]   rem_i,
   input  logic [DIV_W-1:0] quo_i,
   input  logic [DIV_W-1:0] dvs_i,
   output logic [DIV_W:0]   rem_o,
   output logic [DIV_W-1:0] quo_o
);

   logic [DIV_W:0]   sh;
   logic [DIV_W+1:0] trial;
   logic             fits;

   assign sh    = {rem_i[DIV_W-1:0], quo_i[DIV_W-1]};
   assign trial = {1'b0, sh} - {2'b00, dvs_i};
   // A set top remainder bit means the shifted value already exceeds any divisor
   assign fits  = rem_i[DIV_W] | ~trial[DIV_W+1];

   assign rem_o = fits ? trial[DIV_W:0] : sh;
   assign quo_o = {quo_i[DIV_W-2:0], fits};

endmodule
`default_nettype wire

// File: rtl/iter_div.sv
`default_nettype none
// ============================================================================
// iter_div : 32-cycle radix-2 restoring divider, signed or unsigned
// Rev 1.0
// ============================================================================
module iter_div
   import div_pkg::*;
#(
   parameter bit SIGNED = 1'b1
)
(
   input  logic       clk,
   input  logic       reset,
   iter_div_if.slave  bus
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITER - 1);

   div_state_e         state_q;
   logic               dvd_got_q;
   logic               dsr_got_q;
   logic               dvd_neg_q;
   logic               dsr_neg_q;
   logic [DIV_W-1:0]   dvd_raw_q;
   logic [DIV_W-1:0]   dsr_q;
   logic [DIV_W-1:0]   quo_q;
   logic [DIV_W:0]     rem_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*DIV_W-1:0] dout_q;
   logic               dout_vld_q;

   logic               dvd_rdy;
   logic               dsr_rdy;
   logic               dvd_fire;
   logic               dsr_fire;
   logic               dvd_neg;
   logic               dsr_neg;
   logic [DIV_W:0]     step_rem;
   logic [DIV_W-1:0]   step_quo;
   logic [2*DIV_W-1:0] res_d;

   // Ready depends only on state, capture flags and reset, never on tvalid
   assign dvd_rdy  = (state_q == IDLE) && !dvd_got_q && !reset;
   assign dsr_rdy  = (state_q == IDLE) && !dsr_got_q && !reset;
   assign dvd_fire = dvd_rdy && bus.s_axis_dividend_tvalid;
   assign dsr_fire = dsr_rdy && bus.s_axis_divisor_tvalid;
   assign dvd_neg  = SIGNED & bus.s_axis_dividend_tdata[DIV_W-1];
   assign dsr_neg  = SIGNED & bus.s_axis_divisor_tdata[DIV_W-1];

   assign bus.s_axis_dividend_tready = dvd_rdy;
   assign bus.s_axis_divisor_tready  = dsr_rdy;
   assign bus.m_axis_dout_tdata      = dout_q;
   assign bus.m_axis_dout_tvalid     = dout_vld_q;

   iter_div_step u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .dvs_i (dsr_q),
      .rem_o (step_rem),
      .quo_o (step_quo)
   );

   // Final result from the last step; divide-by-zero returns the raw dividend
   always_comb begin
      res_d = '0;
      if (dsr_q == '0) begin
         res_d[QUO_HI:QUO_LO] = '1;
         res_d[REM_HI:REM_LO] = dvd_raw_q;
      end else begin
         res_d[QUO_HI:QUO_LO] = (dvd_neg_q ^ dsr_neg_q) ? (~step_quo + 1'b1) : step_quo;
         res_d[REM_HI:REM_LO] = dvd_neg_q ? (~step_rem[DIV_W-1:0] + 1'b1)
                                          : step_rem[DIV_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         dvd_got_q  <= 1'b0;
         dsr_got_q  <= 1'b0;
         dvd_neg_q  <= 1'b0;
         dsr_neg_q  <= 1'b0;
         dvd_raw_q  <= '0;
         dsr_q      <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (dvd_fire) begin
                  dvd_got_q <= 1'b1;
                  dvd_neg_q <= dvd_neg;
                  dvd_raw_q <= bus.s_axis_dividend_tdata;
                  quo_q     <= div_mag(bus.s_axis_dividend_tdata, dvd_neg);
                  rem_q     <= '0;
               end
               if (dsr_fire) begin
                  dsr_got_q <= 1'b1;
                  dsr_neg_q <= dsr_neg;
                  dsr_q     <= div_mag(bus.s_axis_divisor_tdata, dsr_neg);
               end
               if ((dvd_got_q || dvd_fire) && (dsr_got_q || dsr_fire)) begin
                  state_q <= CALC;
                  cnt_q   <= '0;
               end
            end
            CALC: begin
               rem_q <= step_rem;
               quo_q <= step_quo;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_ITER) begin
                  state_q    <= DONE;
                  dout_q     <= res_d;
                  dout_vld_q <= 1'b1;
               end
            end
            DONE: begin
               state_q    <= IDLE;
               dout_vld_q <= 1'b0;
               dvd_got_q  <= 1'b0;
               dsr_got_q  <= 1'b0;
            end
            default: begin
               state_q    <= IDLE;
               dout_vld_q <= 1'b0;
               dvd_got_q  <= 1'b0;
               dsr_got_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_iter_div.sv
`default_nettype none
// ============================================================================
// tb_iter_div : directed self-checking bench for signed and unsigned iter_div
// Rev 1.0
// ============================================================================
module tb_iter_div;

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   iter_div_if ifu ();
   iter_div_if ifs ();

   iter_div #(.SIGNED(1'b0)) u_dut_u (.clk(clk), .reset(reset), .bus(ifu));
   iter_div #(.SIGNED(1'b1)) u_dut_s (.clk(clk), .reset(reset), .bus(ifs));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit sel, input logic [31:0] dvd, input logic dv,
                        input logic [31:0] dsr, input logic ds);
      if (sel) begin
         ifs.s_axis_dividend_tdata  = dvd;
         ifs.s_axis_dividend_tvalid = dv;
         ifs.s_axis_divisor_tdata   = dsr;
         ifs.s_axis_divisor_tvalid  = ds;
      end else begin
         ifu.s_axis_dividend_tdata  = dvd;
         ifu.s_axis_dividend_tvalid = dv;
         ifu.s_axis_divisor_tdata   = dsr;
         ifu.s_axis_divisor_tvalid  = ds;
      end
   endtask

   function automatic logic get_vld(input bit sel);
      return sel ? ifs.m_axis_dout_tvalid : ifu.m_axis_dout_tvalid;
   endfunction

   function automatic logic [63:0] get_data(input bit sel);
      return sel ? ifs.m_axis_dout_tdata : ifu.m_axis_dout_tdata;
   endfunction

   function automatic logic [1:0] get_rdy(input bit sel);
      return sel ? {ifs.s_axis_dividend_tready, ifs.s_axis_divisor_tready}
                 : {ifu.s_axis_dividend_tready, ifu.s_axis_divisor_tready};
   endfunction

   // Called in the cycle after the capture edge (k=1); lat=-1 on timeout
   task automatic wait_result(input bit sel, output int lat, output logic [63:0] d);
      lat = -1;
      d   = '0;
      for (int k = 1; k <= 60; k++) begin
         if (get_vld(sel)) begin
            lat = k;
            d   = get_data(sel);
            break;
         end
         step();
      end
   endtask

   task automatic op(input bit sel, input logic [31:0] dvd, input logic [31:0] dsr,
                     output int lat, output logic [63:0] d);
      drive(sel, dvd, 1'b1, dsr, 1'b1);
      step();
      drive(sel, 32'h0, 1'b0, 32'h0, 1'b0);
      wait_result(sel, lat, d);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
      step();
      step();
      for (int s = 0; s < 2; s++) begin
         tests++;
         if (get_rdy(s[0]) !== 2'b00) begin
            fails++;
            $display("FAIL reset_rdy_in_reset sel=%0d: got %b expected 00", s, get_rdy(s[0]));
         end
         tests++;
         if (get_vld(s[0]) !== 1'b0 || get_data(s[0]) !== 64'h0) begin
            fails++;
            $display("FAIL reset_dout sel=%0d: got vld=%b data=%h expected vld=0 data=0",
                     s, get_vld(s[0]), get_data(s[0]));
         end
      end
      reset = 1'b0;
      #1;
      for (int s = 0; s < 2; s++) begin
         tests++;
         if (get_rdy(s[0]) !== 2'b11) begin
            fails++;
            $display("FAIL reset_rdy_after sel=%0d: got %b expected 11", s, get_rdy(s[0]));
         end
      end
   endtask

   task automatic test_unsigned_basic();
      int          lat;
      logic [63:0] d;
      op(1'b0, 32'd7, 32'd2, lat, d);
      tests++;
      if (lat !== 33) begin
         fails++;
         $display("FAIL ubasic_latency: got %0d expected 33", lat);
      end
      tests++;
      if (d !== 64'h00000003_00000001) begin
         fails++;
         $display("FAIL ubasic_data: got %h expected 0000000300000001", d);
      end
      step();
      tests++;
      if (get_vld(1'b0) !== 1'b0) begin
         fails++;
         $display("FAIL ubasic_pulse_width: got vld=%b expected 0", get_vld(1'b0));
      end
   endtask

   task automatic test_signed_signs();
      logic [31:0] dvd [3] = '{32'hFFFFFFF9, 32'h00000007, 32'hFFFFFFF9};
      logic [31:0] dsr [3] = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFE};
      logic [63:0] exp [3] = '{64'hFFFFFFFD_FFFFFFFF, 64'hFFFFFFFD_00000001,
                               64'h00000003_FFFFFFFF};
      int          lat;
      logic [63:0] d;
      for (int i = 0; i < 3; i++) begin
         op(1'b1, dvd[i], dsr[i], lat, d);
         tests++;
         if (lat !== 33 || d !== exp[i]) begin
            fails++;
            $display("FAIL signed_%0d: got lat=%0d data=%h expected lat=33 data=%h",
                     i, lat, d, exp[i]);
         end
         step();
      end
   endtask

   task automatic test_staggered();
      int          lat;
      logic [63:0] d;
      drive(1'b0, 32'd100, 1'b1, 32'd0, 1'b0);
      step();
      tests++;
      if (get_rdy(1'b0) !== 2'b01) begin
         fails++;
         $display("FAIL stagger_rdy_c1: got %b expected 01", get_rdy(1'b0));
      end
      // Dividend stays offered with other data; it must be ignored once captured
      drive(1'b0, 32'd50, 1'b1, 32'd0, 1'b0);
      repeat (4) step();
      drive(1'b0, 32'd50, 1'b1, 32'd7, 1'b1);
      tests++;
      if (get_rdy(1'b0) !== 2'b01) begin
         fails++;
         $display("FAIL stagger_rdy_c5: got %b expected 01", get_rdy(1'b0));
      end
      step();
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      tests++;
      if (get_rdy(1'b0) !== 2'b00) begin
         fails++;
         $display("FAIL stagger_rdy_c6: got %b expected 00", get_rdy(1'b0));
      end
      wait_result(1'b0, lat, d);
      tests++;
      if (lat + 5 !== 38) begin
         fails++;
         $display("FAIL stagger_cycle: got %0d expected 38", lat + 5);
      end
      tests++;
      if (d !== 64'h0000000E_00000002) begin
         fails++;
         $display("FAIL stagger_data: got %h expected 0000000E00000002", d);
      end
      step();
   endtask

   task automatic test_corners();
      bit          sel [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [31:0] dvd [5] = '{32'h12345678, 32'h12345678, 32'h80000000,
                               32'hFFFFFFFF, 32'hFFFFFFF9};
      logic [31:0] dsr [5] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0};
      logic [63:0] exp [5] = '{64'hFFFFFFFF_12345678, 64'hFFFFFFFF_12345678,
                               64'h80000000_00000000, 64'hFFFFFFFF_00000000,
                               64'hFFFFFFFF_FFFFFFF9};
      int          lat;
      logic [63:0] d;
      for (int i = 0; i < 5; i++) begin
         op(sel[i], dvd[i], dsr[i], lat, d);
         tests++;
         if (lat !== 33 || d !== exp[i]) begin
            fails++;
            $display("FAIL corner_%0d: got lat=%0d data=%h expected lat=33 data=%h",
                     i, lat, d, exp[i]);
         end
         step();
      end
   endtask

   task automatic test_reset_mid();
      int          lat;
      int          pulses;
      logic [63:0] d;
      drive(1'b1, 32'hFFFFFFF9, 1'b1, 32'd2, 1'b1);
      step();
      drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
      repeat (10) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      for (int s = 0; s < 2; s++) begin
         tests++;
         if (get_rdy(s[0]) !== 2'b11 || get_vld(s[0]) !== 1'b0) begin
            fails++;
            $display("FAIL midreset_state sel=%0d: got rdy=%b vld=%b expected rdy=11 vld=0",
                     s, get_rdy(s[0]), get_vld(s[0]));
         end
      end
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (get_vld(1'b1)) pulses++;
      end
      tests++;
      if (pulses !== 0) begin
         fails++;
         $display("FAIL midreset_no_pulse: got %0d pulses expected 0", pulses);
      end
      op(1'b1, 32'd100, 32'd7, lat, d);
      tests++;
      if (lat !== 33 || d !== 64'h0000000E_00000002) begin
         fails++;
         $display("FAIL midreset_fresh: got lat=%0d data=%h expected lat=33 data=0000000E00000002",
                  lat, d);
      end
      step();
   endtask

   task automatic test_held_valid();
      int   npulse;
      int   pc [4];
      logic prev_vld;
      npulse   = 0;
      prev_vld = 1'b0;
      pc       = '{default: 0};
      drive(1'b0, 32'd1000, 1'b1, 32'd10, 1'b1);
      for (int c = 1; c <= 110; c++) begin
         step();
         if (prev_vld) begin
            tests++;
            if (get_rdy(1'b0) !== 2'b11) begin
               fails++;
               $display("FAIL held_rdy_after_done c=%0d: got %b expected 11", c, get_rdy(1'b0));
            end
         end
         prev_vld = get_vld(1'b0);
         if (prev_vld) begin
            if (npulse < 4) pc[npulse] = c;
            npulse++;
            tests++;
            if (get_data(1'b0) !== 64'h00000064_00000000 || get_rdy(1'b0) !== 2'b00) begin
               fails++;
               $display("FAIL held_done c=%0d: got data=%h rdy=%b expected data=0000006400000000 rdy=00",
                        c, get_data(1'b0), get_rdy(1'b0));
            end
         end
      end
      tests++;
      if (npulse !== 3 || pc[0] !== 33 || pc[1] !== 67 || pc[2] !== 101) begin
         fails++;
         $display("FAIL held_period: got n=%0d at %0d,%0d,%0d expected n=3 at 33,67,101",
                  npulse, pc[0], pc[1], pc[2]);
      end
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      repeat (40) step();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
      test_reset();
      test_unsigned_basic();
      test_signed_signs();
      test_staggered();
      test_corners();
      test_reset_mid();
      test_held_valid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/iter_div.md
# iter_div

Iterative 32-bit radix-2 restoring divider that acts as the responder on the EXE-stage divide handshake. It accepts dividend and divisor on two independent valid/ready channels and computes quotient and remainder over 32 cycles. It then presents `{quotient, remainder}` on a single-cycle-valid result channel. One instance per signedness (`SIGNED=1` for `div`, `SIGNED=0` for `divu`) replaces the vendor divider cores behind the same port names.

## Interface
- `SIGNED`, default 1: 1 = two's-complement operands and results; 0 = unsigned.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `s_axis_dividend_tdata` in 32: dividend.
- `s_axis_dividend_tvalid` in 1: dividend offered.
- `s_axis_dividend_tready` out 1: dividend can be captured this cycle.
- `s_axis_divisor_tdata` in 32: divisor.
- `s_axis_divisor_tvalid` in 1: divisor offered.
- `s_axis_divisor_tready` out 1: divisor can be captured this cycle.
- `m_axis_dout_tdata` out 64: [63:32] quotient, [31:0] remainder.
- `m_axis_dout_tvalid` out 1: result valid, one-cycle pulse. There is no tready; the consumer must sample in that cycle.

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE:**
  - Each channel's tready is 1 until that channel has been captured, then 0.
  - A channel is captured on a clock edge where tvalid && tready.
  - Channels are captured independently, in either order or the same cycle.
  - When both are captured (the second capture may be the current edge), go to CALC with the iteration counter at 0.
- **Operand preparation at capture:**
  - With SIGNED=1, store |operand| plus a sign bit for each operand.
  - With SIGNED=0, store the operand as-is.
- **CALC:** one restoring step per cycle.
  - Shift the {rem[32:0], quo[31:0]} pair left by 1.
  - Compute trial = rem − {0, divisor}.
  - If trial is non-negative, rem = trial and quo[0] = 1; otherwise quo[0] = 0.
  - The counter increments each cycle; after iteration 31, go to DONE.
- **DONE:**
  - Register the result with sign fix: negate the quotient if SIGNED and the dividend and divisor signs differ; negate the remainder if SIGNED and the dividend is negative.
  - m_axis_dout_tvalid = 1 for exactly this cycle; next state is IDLE and the capture flags clear.
- **Divide by zero:** the quotient is 0xFFFFFFFF and the remainder is the dividend, raw, with no sign fix. No exception is raised.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This falls out of the magnitude path.
- **Output hold:** m_axis_dout_tdata holds the last result until the next DONE.
- **Input handling:** inputs offered outside IDLE, or on an already-captured channel, are ignored and not queued.

## Timing
- **Reset values:** state IDLE, capture flags 0, m_axis_dout_tvalid 0, m_axis_dout_tdata 0.
  - Both treadys are 0 while reset is asserted and 1 in the first cycle after.
- **Latency:** if the last operand is captured at the edge ending cycle N, CALC occupies cycles N+1..N+32 and tvalid is high in cycle N+33. The next capture can occur at the edge ending cycle N+34.
- **Ready timing:** treadys are combinational from state and flags only, never from tvalid, so there is no combinational valid→ready path.
- **Reset mid-operation:** any state returns to IDLE on the next edge with no tvalid pulse; a partial result is discarded.
- **Overlap:** DONE and a new tvalid in the same cycle do not capture; capture waits for IDLE.

## Structure
- **Shared package `div_pkg`:**
  - state enum (IDLE/CALC/DONE)
  - `DIV_W = 32`
  - `DIV_ITER = 32`
  - the result field offsets (QUO_HI=63, QUO_LO=32, REM_HI=31, REM_LO=0), shared with EXE-stage HI/LO selection.
- **Sub-module `iter_div_step`:** purely combinational single restoring step that takes {rem, quo, divisor} and returns the next {rem, quo}. The top holds the FSM, the counter and the sign handling.

## Test plan
- **Unsigned basic:** SIGNED=0, dividend 7 and divisor 2 in the same cycle → tvalid exactly 33 cycles later with tdata 0x00000003_00000001; tvalid is low the following cycle.
- **Signed signs:** SIGNED=1 →
  - −7/2 gives 0xFFFFFFFD_FFFFFFFF.
  - 7/−2 gives 0xFFFFFFFD_00000001.
  - −7/−2 gives 0x00000003_FFFFFFFF.
- **Staggered operands:** dividend accepted at cycle 0, divisor tvalid raised at cycle 5 → dividend tready is 0 from cycle 1; divisor is captured at cycle 5; tvalid is in cycle 38.
- **Corner values:**
  - divisor 0 with dividend 0x12345678 gives 0xFFFFFFFF_12345678.
  - SIGNED=1 0x80000000/0xFFFFFFFF gives 0x80000000_00000000.
  - SIGNED=0 0xFFFFFFFF/1 gives 0xFFFFFFFF_00000000.
- **Reset mid-CALC:** reset at iteration 10 → no tvalid pulse; both treadys are 1 after reset deasserts; a fresh 100/7 gives 0x0000000E_00000002.
- **Operands held valid:** both tvalids held high continuously → a new capture occurs only in the cycle after each DONE; results repeat at a 34-cycle period.
